grid_duty_capture: RTL and testbench
====================================

// Module: grid_duty_capture
// PURPOSE
//  Receive-side counterpart of the grid PWM compare path: samples an external
//  PWM/judge line (low while carrier < duty, high otherwise) and recovers the
//  duty (low-time) and period in sysclk counts. Sits on the feedback/monitor
//  path beside the grid PWM generator; results feed the control loop and fault logic.
// PARAMETERS
//  SYNC_STAGES  2       flops in the pwm_in synchroniser (>=2)
//  GLITCH_CYC   3       consecutive equal samples required to accept a level
//  TIMEOUT      60000   max cycles in one level before stuck fault (< 2^16)
// PORTS
//  sysclk        in   1   system clock, all logic on rising edge
//  global_rst    in   1   reset, synchronous, active-low
//  pwm_in        in   1   asynchronous PWM line to measure
//  cap_en        in   1   1 = measure; 0 = forces SEEK, holds outputs
//  meas_dm       out  16  captured low-time (duty compare equivalent)
//  meas_period   out  16  captured period (falling edge to falling edge)
//  meas_valid    out  1   one-cycle pulse when meas_dm/meas_period update
//  stuck_high    out  1   line held high >= TIMEOUT cycles (duty 0)
//  stuck_low     out  1   line held low  >= TIMEOUT cycles (duty full)
// BEHAVIOUR
//  Reset (global_rst=0 at a sysclk edge): all outputs 0, sync/filter flops 0,
//   counters 0, state SEEK. Reset mid-measurement discards partial result.
//  Input path: SYNC_STAGES synchroniser -> glitch filter. Filtered level
//   changes only after GLITCH_CYC consecutive equal synced samples. Edge
//   detect on filtered level; delay identical for both edges, so widths exact.
//  Counter cnt[15:0]: cleared to 1 on the cycle an edge is detected, else +1,
//   saturating at TIMEOUT. Width = cycles between successive edge detects.
//  FSM:
//   SEEK : wait for filtered falling edge -> LOW (cnt=1). Rising edges ignored.
//   LOW  : rising edge -> latch low_w=cnt, HIGH. cnt==TIMEOUT -> STUCK_L.
//   HIGH : falling edge -> meas_dm<=low_w, meas_period<=low_w+cnt (16-bit,
//          saturate at 16'hFFFF), meas_valid=1 next cycle, stay in LOW
//          (new period starts; cnt=1). cnt==TIMEOUT -> STUCK_H.
//   STUCK_L: stuck_low=1, meas_dm<=meas_period (full duty), valid pulse once;
//          rising edge -> clear flag, HIGH (period not yet valid, next publish
//          only after a full low+high pair via SEEK semantics: goes SEEK).
//   STUCK_H: stuck_high=1, meas_dm<=0, valid pulse once; falling edge ->
//          clear flag, LOW.
//  First valid result: after first falling edge, one low, one high, next falling.
//  meas_valid latency: 1 cycle after the filtered falling edge is detected.
//  Outputs registered; meas_dm/meas_period hold between pulses.
//  cap_en=0: state SEEK, cnt 0, flags cleared, no pulses; results held.
//  Edge on same cycle as TIMEOUT reached: edge wins (normal transition).
//  Glitch shorter than GLITCH_CYC: no edge, counts unaffected.
// STRUCTURE
//  Shared package grid_pkg: state enum (SEEK/LOW/HIGH/STUCK_L/STUCK_H),
//   CNT_W=16, default TIMEOUT constant (shared with grid PWM generator).
//  One sub-module: grid_sync_filter (synchroniser + glitch filter, outputs
//   filtered level, rise pulse, fall pulse). FSM/counters in top.
// TESTING
//  1 reset: global_rst=0 2 cycles with pwm_in toggling -> all outputs 0, no valid.
//  2 steady PWM low 300 / high 700 cycles -> meas_dm=300, meas_period=1000,
//    meas_valid one cycle per period; first pulse after second falling edge.
//  3 2-cycle glitch mid-high (GLITCH_CYC=3) -> results unchanged 300/1000.
//  4 line held high 60000 cycles -> stuck_high=1, meas_dm=0, single valid;
//    resume PWM -> flag clears on falling edge, 300/1000 restored.
//  5 line held low 60000 -> stuck_low=1, meas_dm=meas_period; resumes cleanly.
//  6 global_rst=0 mid-LOW, or cap_en=0 mid-HIGH -> partial period dropped,
//    outputs per rule, next valid only after a full new period.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared definitions for the grid PWM generator and the duty-capture monitor.
package grid_pkg;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT_DEF = 60000;

  typedef enum logic [2:0] {
    SEEK    = 3'd0,
    LOW     = 3'd1,
    HIGH    = 3'd2,
    STUCK_L = 3'd3,
    STUCK_H = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/grid_duty_capture_if.sv
// Measurement bus of the duty-capture monitor: PWM line and enable in, results out.
// meas_valid is a one-cycle, valid-only pulse (no ready): consumers must take
// meas_dm/meas_period in the cycle it is high; the values then hold until the next pulse.
interface grid_duty_capture_if;
  import grid_pkg::*;

  logic             pwm_in;
  logic             cap_en;
  logic [CNT_W-1:0] meas_dm;
  logic [CNT_W-1:0] meas_period;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;
  state_t           dbg_state;
  logic             dbg_level;

  modport master (
    output pwm_in, cap_en,
    input  meas_dm, meas_period, meas_valid, stuck_high, stuck_low, dbg_state, dbg_level
  );

  modport slave (
    input  pwm_in, cap_en,
    output meas_dm, meas_period, meas_valid, stuck_high, stuck_low, dbg_state, dbg_level
  );
endinterface

// File: rtl/grid_sync_filter.sv
// Synchroniser plus glitch filter for an asynchronous PWM line; emits the
// filtered level and single-cycle rise/fall pulses with equal latency.
module grid_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int GW = $clog2(GLITCH_CYC + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [GW-1:0]          r_run;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;
  logic                   w_accept;

  assign w_synced = r_sync[SYNC_STAGES-1];
  // r_run counts prior consecutive samples that disagreed with the filtered level.
  assign w_accept = (w_synced != r_level) && (r_run == GW'(GLITCH_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_run   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if ((w_synced == r_level) || w_accept) begin
        r_run <= '0;
      end else begin
        r_run <= r_run + GW'(1);
      end
      if (w_accept) begin
        r_level <= w_synced;
      end
      r_rise <= w_accept & w_synced;
      r_fall <= w_accept & ~w_synced;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/grid_duty_capture.sv
// Recovers low-time and period of an external PWM line in sysclk counts,
// with stuck-high/stuck-low detection after TIMEOUT cycles in one level.
module grid_duty_capture
  import grid_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 3,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                sysclk,
  input  logic                global_rst,
  grid_duty_capture_if.slave  cap
);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;

  state_t           r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [CNT_W-1:0] r_low_w,   w_low_w_nxt;
  logic [CNT_W-1:0] r_dm,      w_dm_nxt;
  logic [CNT_W-1:0] r_period,  w_period_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_stuck_h, w_stuck_h_nxt;
  logic             r_stuck_l, w_stuck_l_nxt;

  grid_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH_CYC  (GLITCH_CYC)
  ) u_sync_filter (
    .i_clk   (sysclk),
    .i_rst_n (global_rst),
    .i_raw   (cap.pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge = w_rise | w_fall;

  always_ff @(posedge sysclk) begin
    if (!global_rst) begin
      r_state   <= SEEK;
      r_cnt     <= '0;
      r_low_w   <= '0;
      r_dm      <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_stuck_h <= 1'b0;
      r_stuck_l <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_low_w   <= w_low_w_nxt;
      r_dm      <= w_dm_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_stuck_h <= w_stuck_h_nxt;
      r_stuck_l <= w_stuck_l_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_low_w_nxt   = r_low_w;
    w_dm_nxt      = r_dm;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_stuck_h_nxt = r_stuck_h;
    w_stuck_l_nxt = r_stuck_l;

    if (w_edge) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (r_cnt != TO_CNT) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // Edge tests come before the timeout tests so an edge on the timeout cycle wins.
    unique case (r_state)
      SEEK: begin
        if (w_fall) w_state_nxt = LOW;
      end
      LOW: begin
        if (w_rise) begin
          w_low_w_nxt = r_cnt;
          w_state_nxt = HIGH;
        end else if (r_cnt == TO_CNT) begin
          w_stuck_l_nxt = 1'b1;
          w_dm_nxt      = r_period;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = STUCK_L;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_dm_nxt     = r_low_w;
          w_period_nxt = sat_add(r_low_w, r_cnt);
          w_valid_nxt  = 1'b1;
          w_state_nxt  = LOW;
        end else if (r_cnt == TO_CNT) begin
          w_stuck_h_nxt = 1'b1;
          w_dm_nxt      = '0;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = STUCK_H;
        end
      end
      STUCK_L: begin
        // The low phase before this rise is unmeasured, so restart from a falling edge.
        if (w_rise) begin
          w_stuck_l_nxt = 1'b0;
          w_state_nxt   = SEEK;
        end
      end
      STUCK_H: begin
        if (w_fall) begin
          w_stuck_h_nxt = 1'b0;
          w_state_nxt   = LOW;
        end
      end
      default: w_state_nxt = SEEK;
    endcase

    if (!cap.cap_en) begin
      w_state_nxt   = SEEK;
      w_cnt_nxt     = '0;
      w_low_w_nxt   = r_low_w;
      w_dm_nxt      = r_dm;
      w_period_nxt  = r_period;
      w_valid_nxt   = 1'b0;
      w_stuck_h_nxt = 1'b0;
      w_stuck_l_nxt = 1'b0;
    end
  end

  assign cap.meas_dm     = r_dm;
  assign cap.meas_period = r_period;
  assign cap.meas_valid  = r_valid;
  assign cap.stuck_high  = r_stuck_h;
  assign cap.stuck_low   = r_stuck_l;
  assign cap.dbg_state   = r_state;
  assign cap.dbg_level   = w_level;
endmodule

// File: tb/tb_grid_duty_capture.sv
// Directed and randomized PWM segments checked against a segment-level model
// of the expected published results.
module tb_grid_duty_capture;
  localparam int TO_TB = 2000;

  localparam int P_SEEK = 0;
  localparam int P_LOW  = 1;
  localparam int P_HIGH = 2;
  localparam int P_STL  = 3;
  localparam int P_STH  = 4;

  logic sysclk = 1'b0;
  logic global_rst = 1'b0;

  grid_duty_capture_if ifc ();

  grid_duty_capture #(
    .SYNC_STAGES (2),
    .GLITCH_CYC  (3),
    .TIMEOUT     (TO_TB)
  ) dut (
    .sysclk     (sysclk),
    .global_rst (global_rst),
    .cap        (ifc.slave)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected publications: {stuck_high, stuck_low, meas_dm, meas_period}
  logic [33:0] exp_q[$];

  bit m_prev    = 1'b0;
  int m_cur_len = 0;
  int m_low     = 0;
  int m_phase   = P_SEEK;
  int m_dm      = 0;
  int m_per     = 0;
  bit m_sh      = 1'b0;
  bit m_sl      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push_rec();
    exp_q.push_back({m_sh, m_sl, 16'(m_dm), 16'(m_per)});
  endfunction

  // Apply the measurement rules to one raw segment of constant level.
  function automatic void model_seg(input bit lvl, input int len);
    if (lvl != m_prev) begin
      if (!lvl) begin
        if (m_phase == P_HIGH) begin
          m_dm  = m_low;
          m_per = (m_low + m_cur_len > 65535) ? 65535 : m_low + m_cur_len;
          push_rec();
          m_phase = P_LOW;
        end else if (m_phase == P_STH) begin
          m_sh    = 1'b0;
          m_phase = P_LOW;
        end else if (m_phase == P_SEEK) begin
          m_phase = P_LOW;
        end
      end else begin
        if (m_phase == P_LOW) begin
          m_low   = m_cur_len;
          m_phase = P_HIGH;
        end else if (m_phase == P_STL) begin
          m_sl    = 1'b0;
          m_phase = P_SEEK;
        end
      end
      m_cur_len = 0;
    end
    m_cur_len += len;
    m_prev = lvl;
    if (m_cur_len > TO_TB) begin
      if (!lvl && m_phase == P_LOW) begin
        m_dm    = m_per;
        m_sl    = 1'b1;
        m_phase = P_STL;
        push_rec();
      end else if (lvl && m_phase == P_HIGH) begin
        m_dm    = 0;
        m_sh    = 1'b1;
        m_phase = P_STH;
        push_rec();
      end
    end
  endfunction

  task automatic seg(input bit lvl, input int len);
    model_seg(lvl, len);
    ifc.pwm_in = lvl;
    repeat (len) @(negedge sysclk);
  endtask

  task automatic glitch(input int len);
    ifc.pwm_in = ~m_prev;
    repeat (len) @(negedge sysclk);
    ifc.pwm_in = m_prev;
    m_cur_len += len;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_dm"},      32'(ifc.meas_dm), 32'(m_dm));
    chk({tag, "_period"},  32'(ifc.meas_period), 32'(m_per));
    chk({tag, "_stuck_h"}, 32'(ifc.stuck_high), 32'(m_sh));
    chk({tag, "_stuck_l"}, 32'(ifc.stuck_low), 32'(m_sl));
  endtask

  task automatic step_check(input string tag);
    seg(m_prev, 20);
    check_outputs(tag);
  endtask

  always @(negedge sysclk) begin
    if (global_rst && ifc.meas_valid === 1'b1) begin
      chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [33:0] rec;
        rec = exp_q.pop_front();
        chk("pulse_dm",      32'(ifc.meas_dm), 32'(rec[31:16]));
        chk("pulse_period",  32'(ifc.meas_period), 32'(rec[15:0]));
        chk("pulse_stuck_l", 32'(ifc.stuck_low), 32'(rec[32]));
        chk("pulse_stuck_h", 32'(ifc.stuck_high), 32'(rec[33]));
      end
    end
  end

  initial begin
    ifc.cap_en = 1'b1;
    ifc.pwm_in = 1'b0;

    // Reset with the line toggling.
    global_rst = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      ifc.pwm_in = ~ifc.pwm_in;
    end
    chk("rst_valid", 32'(ifc.meas_valid), 32'd0);
    check_outputs("rst");
    ifc.pwm_in = 1'b0;
    @(negedge sysclk);
    global_rst = 1'b1;
    repeat (10) @(negedge sysclk);
    chk("idle_valid", 32'(ifc.meas_valid), 32'd0);

    // Steady 300/700 PWM; first publication on the second falling edge.
    seg(1, 200);
    for (int i = 0; i < 4; i++) begin
      seg(0, 300);
      seg(1, 700);
    end
    step_check("steady");

    // Short glitch inside the high phase must not disturb the widths.
    seg(0, 300);
    seg(1, 350);
    glitch(2);
    seg(1, 348);
    seg(0, 300);
    seg(1, 700);
    step_check("glitch");

    // Stuck high, then recovery.
    seg(0, 300);
    seg(1, TO_TB + 100);
    step_check("stuck_h");
    seg(0, 300);
    seg(1, 700);
    seg(0, 300);
    seg(1, 700);
    step_check("resume_h");

    // Stuck low, then recovery.
    seg(0, TO_TB + 100);
    step_check("stuck_l");
    seg(1, 700);
    seg(0, 300);
    seg(1, 700);
    seg(0, 300);
    seg(1, 700);
    step_check("resume_l");

    // Low exactly TIMEOUT: edge wins. One cycle longer: stuck.
    seg(0, TO_TB);
    seg(1, 700);
    seg(0, 300);
    seg(1, 700);
    step_check("low_eq_to");
    seg(0, TO_TB + 1);
    seg(1, 700);
    step_check("low_to_plus1");

    // Randomized widths.
    for (int i = 0; i < 8; i++) begin
      seg(0, $urandom_range(900, 50));
      seg(1, $urandom_range(900, 50));
    end
    seg(0, 300);
    seg(1, 700);
    step_check("random");

    // Reset in the middle of a low phase discards the partial period.
    seg(0, 100);
    global_rst = 1'b0;
    repeat (2) @(negedge sysclk);
    m_phase = P_SEEK;
    m_dm = 0;
    m_per = 0;
    m_sh = 1'b0;
    m_sl = 1'b0;
    check_outputs("mid_rst");
    global_rst = 1'b1;
    seg(0, 100);
    seg(1, 700);
    seg(0, 300);
    seg(1, 700);
    step_check("post_rst");
    seg(0, 300);
    seg(1, 700);
    step_check("post_rst_full");

    // Capture disabled in the middle of a high phase.
    seg(0, 300);
    seg(1, 300);
    ifc.cap_en = 1'b0;
    m_phase = P_SEEK;
    m_sh = 1'b0;
    m_sl = 1'b0;
    seg(1, 30);
    check_outputs("cap_off");
    ifc.cap_en = 1'b1;
    seg(1, 370);
    seg(0, 300);
    seg(1, 700);
    step_check("cap_on");
    seg(0, 300);
    seg(1, 100);
    step_check("cap_full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
